// File: rtl/inst_line_buf_pkg.sv
// Shared definitions for the single-line instruction fetch buffer:
// controller state encoding, the NOP reset word and a line-base helper.
package inst_line_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // addi x0,x0,0 -- harmless instruction presented on INST_RDATA out of reset
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Clear the byte/word offset bits so the address points at the start of its line
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_w);
    return addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/inst_line_buf.sv
// One-line instruction buffer: serves fetches from a buffered line and refills
// it with a burst read on a miss; flushes during a refill drain the burst.
module inst_line_buf
  import inst_line_buf_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MEM_WAIT,
  output logic        MEM_ARVALID,
  input  logic        MEM_ARREADY,
  output logic [31:0] MEM_ARADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_RLAST
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = 32 - OFF_W;

  state_t             state_reg;
  logic               valid_reg;
  logic               cancel_reg;
  logic [IDX_W-1:0]   beat_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [31:0]        line_mem [LINE_WORDS];

  logic               rvalid_reg;
  logic [31:0]        roaddr_reg;
  logic [31:0]        rdata_reg;
  logic               arvalid_reg;
  logic [31:0]        araddr_reg;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_word;
  logic               lookup;
  logic               tag_match;
  logic               hit;
  logic               miss;
  logic               beat_write;

  assign req_tag   = INST_RIADDR[31:OFF_W];
  assign req_word  = INST_RIADDR[OFF_W-1:2];
  assign lookup    = INST_RDEN & ~FLUSH & (state_reg == ST_IDLE);
  assign tag_match = valid_reg & (req_tag == tag_reg);
  assign hit       = lookup & tag_match;
  assign miss      = lookup & ~tag_match;
  assign beat_write = ~RST & (state_reg == ST_DATA) & MEM_RVALID;

  assign MEM_WAIT    = (state_reg != ST_IDLE) | miss;
  // A flush kills the response issued by last cycle's hit
  assign INST_RVALID = rvalid_reg & ~FLUSH;
  assign INST_ROADDR = roaddr_reg;
  assign INST_RDATA  = rdata_reg;
  assign MEM_ARVALID = arvalid_reg;
  assign MEM_ARADDR  = araddr_reg;

  // Line storage: no reset needed, the valid bit guards every read
  always_ff @(posedge CLK) begin
    if (beat_write) begin
      line_mem[beat_reg] <= MEM_RDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      valid_reg   <= 1'b0;
      cancel_reg  <= 1'b0;
      beat_reg    <= '0;
      tag_reg     <= '0;
      rvalid_reg  <= 1'b0;
      roaddr_reg  <= 32'h0;
      rdata_reg   <= NOP_INST;
      arvalid_reg <= 1'b0;
      araddr_reg  <= 32'h0;
    end else begin
      rvalid_reg <= hit;
      if (hit) begin
        roaddr_reg <= INST_RIADDR;
        rdata_reg  <= line_mem[req_word];
      end

      case (state_reg)
        ST_IDLE: begin
          if (miss) begin
            state_reg   <= ST_ADDR;
            valid_reg   <= 1'b0;
            arvalid_reg <= 1'b1;
            araddr_reg  <= line_base(INST_RIADDR, OFF_W);
          end
        end

        ST_ADDR: begin
          if (FLUSH) begin
            cancel_reg <= 1'b1;
          end
          if (MEM_ARREADY) begin
            arvalid_reg <= 1'b0;
            beat_reg    <= '0;
            state_reg   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (FLUSH) begin
            cancel_reg <= 1'b1;
          end
          if (MEM_RVALID) begin
            beat_reg <= beat_reg + IDX_W'(1);
            if (MEM_RLAST) begin
              state_reg  <= ST_IDLE;
              beat_reg   <= '0;
              cancel_reg <= 1'b0;
              // A flush arriving with the last beat still cancels the fill
              if (!(cancel_reg | FLUSH)) begin
                valid_reg <= 1'b1;
                tag_reg   <= araddr_reg[31:OFF_W];
              end
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_line_buf.md
INST_LINE_BUF -- requirements
Module: inst_line_buf

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per buffered line (power of two, >=2).
REQ-002 SHALL have ports: CLK in 1 (clock); RST in 1 (synchronous active-high reset); FLUSH in 1 (pipeline flush).
REQ-003 SHALL have ports: INST_RDEN in 1 (fetch request); INST_RIADDR in 32 (fetch address).
REQ-004 SHALL have ports: INST_RVALID out 1; INST_ROADDR out 32; INST_RDATA out 32 (response to fetch).
REQ-005 SHALL have port MEM_WAIT out 1, meaning the fetch stage holds its PC.
REQ-006 SHALL have ports: MEM_ARVALID out 1; MEM_ARREADY in 1; MEM_ARADDR out 32 (burst address channel).
REQ-007 SHALL have ports: MEM_RVALID in 1; MEM_RDATA in 32; MEM_RLAST in 1 (burst data channel).
REQ-008 SHALL use one clock, CLK; RST SHALL be synchronous and active-high.

Function
REQ-009 SHALL hold one line: tag = addr[31:log2(LINE_WORDS)+2], LINE_WORDS data words, one valid bit.
REQ-010 SHALL ignore addr[1:0] for tag compare, word select and burst address.
REQ-011 Hit = INST_RDEN & !FLUSH & state IDLE & valid & tag match.
REQ-012 On a hit in cycle N, SHALL drive INST_RVALID=1 in N+1 for exactly one cycle, with INST_ROADDR = requested address and INST_RDATA = selected word.
REQ-013 INST_RVALID SHALL be 0 in every cycle not produced by REQ-012.
REQ-014 Miss in IDLE SHALL enter ADDR and latch line base = addr with low log2(LINE_WORDS)+2 bits zeroed.
REQ-015 MEM_WAIT SHALL be combinational: 1 on an IDLE miss and in every non-IDLE state; 0 otherwise.
REQ-016 In ADDR, SHALL hold MEM_ARVALID=1 and MEM_ARADDR=line base, stable until MEM_ARREADY.
REQ-017 ADDR->DATA SHALL occur on the MEM_ARVALID & MEM_ARREADY cycle.
REQ-018 In DATA, each MEM_RVALID beat SHALL be written to word index 0,1,2,... in order.
REQ-019 The beat with MEM_RLAST=1 SHALL return the block to IDLE.
REQ-020 At that beat, SHALL set tag and valid=1 unless cancelled (REQ-022).
REQ-021 valid SHALL be cleared on entry to ADDR, so a partial line is never hit.
REQ-022 FLUSH while ADDR or DATA SHALL set a cancel flag and SHALL NOT abort the bus transaction.
REQ-023 Under cancel, ARVALID SHALL stay asserted until accepted, then all beats SHALL be drained and discarded, and valid SHALL stay 0; cancel SHALL clear on return to IDLE.
REQ-024 FLUSH in IDLE SHALL suppress any hit or miss that cycle; a pending INST_RVALID from the previous cycle SHALL be forced to 0.
REQ-025 The held fetch request after a non-cancelled fill SHALL hit in the first IDLE cycle; MEM_RVALID outside DATA SHALL be ignored.
REQ-026 FLUSH and MEM_RLAST in the same cycle SHALL count as cancelled.

Reset
REQ-027 RST SHALL set: state IDLE, valid=0, cancel=0, beat index=0, INST_RVALID=0, INST_ROADDR=0, INST_RDATA=32'h0000_0013, MEM_ARVALID=0, MEM_ARADDR=0.
REQ-028 RST SHALL override all other inputs, including mid-burst; the bench SHALL reset the bus model alongside.

Structure
REQ-029 State encoding (IDLE, ADDR, DATA) and NOP value 32'h0000_0013 SHALL be placed in the shared core package.
REQ-030 SHALL be a single module; no sub-module required.

Verification
REQ-031 Cold miss: RST, RDEN=1, RIADDR=32'h2000_0004, ARREADY 2 cycles later, beats 11,22,33,44 (RLAST on 44) -> one AR at 32'h2000_0000; MEM_WAIT high until IDLE; then RVALID with ROADDR=32'h2000_0004, RDATA=22.
REQ-032 Sequential hits: after REQ-031, requests 32'h2000_0008 then 32'h2000_000C -> RVALID on consecutive cycles, data 33, 44, MEM_WAIT=0, no AR.
REQ-033 Line crossing: request 32'h2000_0010 -> new AR at 32'h2000_0010; valid clear until its RLAST.
REQ-034 Flush mid-DATA: FLUSH after beat 2 -> remaining beats drained; no RVALID; next request to 32'h2000_0000 misses again.
REQ-035 Flush during ADDR with ARREADY low 5 cycles -> ARVALID and ARADDR stable throughout; burst drained; valid=0.
REQ-036 Reset mid-burst: RST during DATA -> next cycle state IDLE, all outputs at REQ-027 values.
